// File: rtl/video_vram_port.sv
`default_nettype none
// ============================================================================
// Module      : video_vram_port
// Description : Host-side PPU VRAM access port. Holds the v/t/x scroll and
//               address registers with the shared write toggle, performs
//               single-byte VRAM writes and buffered VRAM reads with an
//               automatic address increment of 1 or 32.
// Revision    : 1.0 - initial release
// ============================================================================
module video_vram_port #(
    parameter int P_read_latency = 1
) (
    input  wire         I_clock,
    input  wire         I_reset,
    input  wire  [7:0]  I_host_data,
    input  wire         I_ctrl_wr,
    input  wire         I_scrl_wr,
    input  wire         I_addr_wr,
    input  wire         I_data_wr,
    input  wire         I_data_rd,
    input  wire         I_stat_rd,
    input  wire         I_inc32,
    output logic [13:0] O_vid_addr,
    output logic        O_vid_wren,
    input  wire  [7:0]  I_vid_data,
    output logic [7:0]  O_vid_data,
    output logic [7:0]  O_read_data,
    output logic        O_busy,
    output logic [14:0] O_v,
    output logic [14:0] O_t,
    output logic [2:0]  O_fine_x
);

    localparam logic [1:0]  c_ST_IDLE      = 2'd0;
    localparam logic [1:0]  c_ST_WRITE     = 2'd1;
    localparam logic [1:0]  c_ST_READ_WAIT = 2'd2;
    localparam logic [1:0]  c_ST_READ_CAP  = 2'd3;
    // Last READ_WAIT count before the VRAM data is valid.
    localparam logic [1:0]  c_LAT_LAST     = 2'(P_read_latency - 1);
    localparam logic [14:0] c_INC_1        = 15'd1;
    localparam logic [14:0] c_INC_32       = 15'd32;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  r_lat;
    logic [14:0] r_v;
    logic [14:0] r_t;
    logic [2:0]  r_x;
    logic        r_w;
    logic [7:0]  r_rbuf;
    logic [7:0]  r_wdata;

    logic        w_ctrl;
    logic        w_scrl;
    logic        w_addr;
    logic        w_dwr;
    logic        w_drd;
    logic        w_srd;
    logic        w_inc;

    // Only the highest-priority strobe of the cycle is allowed to act.
    always_comb begin
        w_ctrl = I_ctrl_wr;
        w_scrl = I_scrl_wr & ~I_ctrl_wr;
        w_addr = I_addr_wr & ~I_ctrl_wr & ~I_scrl_wr;
        w_dwr  = I_data_wr & ~I_ctrl_wr & ~I_scrl_wr & ~I_addr_wr;
        w_drd  = I_data_rd & ~I_ctrl_wr & ~I_scrl_wr & ~I_addr_wr & ~I_data_wr;
        w_srd  = I_stat_rd & ~I_ctrl_wr & ~I_scrl_wr & ~I_addr_wr & ~I_data_wr
                 & ~I_data_rd;
        w_inc  = (r_state == c_ST_WRITE) || (r_state == c_ST_READ_CAP);
    end

    // Access sequencer; data strobes outside IDLE are simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_dwr) begin
                    w_state_nxt = c_ST_WRITE;
                end else if (w_drd) begin
                    w_state_nxt = c_ST_READ_WAIT;
                end
            end
            c_ST_WRITE:     w_state_nxt = c_ST_IDLE;
            c_ST_READ_WAIT: begin
                if (r_lat == c_LAT_LAST) begin
                    w_state_nxt = c_ST_READ_CAP;
                end
            end
            default:        w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State, scroll/address registers and data latches.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_state <= c_ST_IDLE;
            r_lat   <= 2'd0;
            r_v     <= 15'd0;
            r_t     <= 15'd0;
            r_x     <= 3'd0;
            r_w     <= 1'b0;
            r_rbuf  <= 8'd0;
            r_wdata <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_lat   <= (r_state == c_ST_READ_WAIT) ? r_lat + 2'd1 : 2'd0;

            // A second-write address load overrides a pending increment.
            if (w_addr && r_w) begin
                r_v <= {r_t[14:8], I_host_data};
            end else if (w_inc) begin
                r_v <= r_v + (I_inc32 ? c_INC_32 : c_INC_1);
            end

            if (w_ctrl) begin
                r_t[11:10] <= I_host_data[1:0];
            end else if (w_scrl) begin
                if (!r_w) begin
                    r_t[4:0] <= I_host_data[7:3];
                    r_x      <= I_host_data[2:0];
                end else begin
                    r_t[14:12] <= I_host_data[2:0];
                    r_t[9:5]   <= I_host_data[7:3];
                end
                r_w <= ~r_w;
            end else if (w_addr) begin
                if (!r_w) begin
                    r_t[13:8] <= I_host_data[5:0];
                    r_t[14]   <= 1'b0;
                end else begin
                    r_t[7:0]  <= I_host_data;
                end
                r_w <= ~r_w;
            end else if (w_srd) begin
                r_w <= 1'b0;
            end

            if ((r_state == c_ST_IDLE) && w_dwr) begin
                r_wdata <= I_host_data;
            end

            if (r_state == c_ST_READ_CAP) begin
                r_rbuf <= I_vid_data;
            end
        end
    end

    assign O_vid_addr  = r_v[13:0];
    assign O_vid_wren  = (r_state == c_ST_WRITE);
    assign O_busy      = (r_state != c_ST_IDLE);
    assign O_vid_data  = r_wdata;
    assign O_read_data = r_rbuf;
    assign O_v         = r_v;
    assign O_t         = r_t;
    assign O_fine_x    = r_x;

endmodule
`default_nettype wire

// File: doc/video_vram_port.md
VIDEO_VRAM_PORT -- requirements
Module: video_vram_port

Interface
REQ-001 Parameter P_read_latency, default 1: I_clock cycles from O_vid_addr valid to I_vid_data valid; legal range 1-4.
REQ-002 I_clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 I_reset  in  1  reset, synchronous, active-high.
REQ-004 I_host_data  in  8  latched host write byte; sampled only when a write strobe is high.
REQ-005 I_ctrl_wr, I_scrl_wr, I_addr_wr, I_data_wr  in  1 each  single-cycle write-rise strobes for PPUCTRL, PPUSCROLL, PPUADDR and PPUDATA.
REQ-006 I_data_rd, I_stat_rd  in  1 each  single-cycle read-fall strobes for PPUDATA and PPUSTATUS.
REQ-007 I_inc32  in  1  PPUCTRL bit 2; 1 selects increment 32, 0 selects increment 1.
REQ-008 O_vid_addr  out  14  VRAM address.
REQ-009 O_vid_wren  out  1  VRAM write enable.
REQ-010 I_vid_data  in  8  VRAM read data.
REQ-011 O_vid_data  out  8  VRAM write data.
REQ-012 O_read_data  out  8  PPUDATA read buffer presented to the host mux.
REQ-013 O_busy  out  1  access in progress.
REQ-014 O_v  out  15, O_t  out  15, O_fine_x  out  3  scroll and address registers exported for the renderer.

Function
REQ-015 Internal state: v[14:0], t[14:0], x[2:0], write toggle w, read buffer rbuf[7:0], FSM {IDLE, WRITE, READ_WAIT, READ_CAP}.
REQ-016 I_ctrl_wr: t[11:10] <= I_host_data[1:0]; w is unchanged.
REQ-017 I_scrl_wr with w=0: t[4:0] <= d[7:3], x <= d[2:0], w <= 1.
REQ-018 I_scrl_wr with w=1: t[14:12] <= d[2:0], t[9:5] <= d[7:3], w <= 0.
REQ-019 I_addr_wr with w=0: t[13:8] <= d[5:0], t[14] <= 0, w <= 1.
REQ-020 I_addr_wr with w=1: t[7:0] <= d, v <= {t[14:8], d} in the same edge, w <= 0.
REQ-021 I_stat_rd: w <= 0; no other effect.
REQ-022 Register strobes (REQ-016 to REQ-021) are accepted in every FSM state.
REQ-023 If more than one strobe is high in a cycle, only the highest-priority strobe acts, in the order ctrl > scrl > addr > data_wr > data_rd > stat_rd.
REQ-024 IDLE + I_data_wr: latch d into O_vid_data and enter WRITE.
REQ-025 WRITE lasts 1 cycle with O_vid_wren=1 and O_vid_addr=v[13:0]; it then applies the increment and returns to IDLE.
REQ-026 IDLE + I_data_rd: enter READ_WAIT, which drives O_vid_addr=v[13:0] for P_read_latency cycles.
REQ-027 READ_CAP lasts 1 cycle: rbuf <= I_vid_data, increment, then IDLE.
REQ-028 O_read_data = rbuf at all times, so the host receives the value fetched by the previous read.
REQ-029 Palette range $3F00-$3FFF gets no special treatment and is buffered like any other address.
REQ-030 Increment: v <= (v + (I_inc32 ? 32 : 1)) mod 2^15; I_inc32 is sampled in the increment cycle; v[14] wraps to 0.
REQ-031 O_vid_addr shows v[13:0] in every state.
REQ-032 O_vid_wren is 1 only in WRITE.
REQ-033 O_busy is 1 in WRITE, READ_WAIT and READ_CAP.
REQ-034 I_data_wr or I_data_rd while O_busy=1 is ignored: no queueing and no state change.
REQ-035 If an I_addr_wr with w=1 lands in the increment cycle, the v load from REQ-020 wins and the increment is discarded; rbuf capture still occurs.
REQ-036 I_vid_data is sampled only in READ_CAP.

Reset
REQ-037 While I_reset is 1 on a clock edge: v, t, x, w, rbuf and O_vid_data go to 0, O_vid_wren=0, O_busy=0, FSM=IDLE.
REQ-038 Reset mid-access aborts the access: no write pulse completes and no increment occurs.
REQ-039 Reset dominates every strobe in the same cycle.

Verification
REQ-040 addr_wr $21, addr_wr $08, then data_wr $5A with inc32=0 -> exactly one wren pulse at addr $2108 with data $5A; v ends at $2109.
REQ-041 v=$2000, inc32=1; two data_rd with I_vid_data=$11 then $22 (model latency 1) -> O_read_data is $11 after the first read and $22 after the second; v ends at $2040.
REQ-042 scrl_wr $7D, scrl_wr $5E -> t=$616F, x=5, w=0; ctrl_wr $03 then gives t=$6D6F.
REQ-043 addr_wr $3F, stat_rd, addr_wr $10 -> w reset by stat_rd, so t[13:8]=$10 and v unchanged, w=1.
REQ-044 v=$7FFF, data_wr with inc32=0 -> write at $3FFF, v wraps to $0000; a second data_wr while O_busy=1 is ignored, wren pulse count stays 1.
REQ-045 Assert I_reset in READ_WAIT -> next cycle O_busy=0, v=0, rbuf=0; no capture or increment follows.
